fifo_row_packer: RTL and testbench

//  Downstream consumer of the 4-bit FIFO row stream produced by fifo_two_cycle_row behind the AXI-Lite slave.

---
 rtl/fifo_row_packer.sv | 110 +++++++++++
 tb/tb_fifo_row_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_row_packer.sv
// Packs a 4-bit nibble stream into row words and buffers completed rows in a
// 2-entry valid/ready output queue; nibbles arriving with no room are dropped and flagged.
module fifo_row_packer #(
  parameter int NIBBLES_PER_ROW = 8,  // legal range 2..16
  parameter int CNT_W           = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  input  logic [3:0]                   in_data,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         clr_ovf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*NIBBLES_PER_ROW-1:0] out_data,
  output logic [4:0]                   out_nibbles,
  output logic                         overflow,
  output logic [CNT_W-1:0]             row_count
);

  localparam int         W    = 4 * NIBBLES_PER_ROW;
  localparam logic [4:0] LAST = 5'(NIBBLES_PER_ROW - 1);

  logic [4:0]       r_nib_idx;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_q_data [2];
  logic [4:0]       r_q_nib  [2];
  logic             r_head;
  logic [1:0]       r_q_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_row_count;

  logic         w_accept;
  logic         w_drop;
  logic         w_pop;
  logic         w_row_done;
  logic         w_flush_ok;
  logic         w_push;
  logic         w_tail;
  logic [W-1:0] w_acc_next;
  logic [4:0]   w_push_nib;

  // Only one slot must be free to finish a row, so in_ready never looks at out_ready.
  assign in_ready   = (r_nib_idx != LAST) || (r_q_count != 2'd2);
  assign w_accept   = in_valid && in_ready;
  assign w_drop     = in_valid && !in_ready;
  assign out_valid  = (r_q_count != 2'd0);
  assign w_pop      = out_valid && out_ready;
  assign w_row_done = w_accept && (r_nib_idx == LAST);
  assign w_flush_ok = flush && (r_nib_idx != 5'd0) && (r_q_count != 2'd2);
  assign w_push     = w_row_done || w_flush_ok;
  assign w_tail     = r_head ^ r_q_count[0];

  always_comb begin
    w_acc_next = r_acc;
    if (w_accept) w_acc_next[4*r_nib_idx +: 4] = in_data;
    w_push_nib = w_accept ? (r_nib_idx + 5'd1) : r_nib_idx;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_nib_idx   <= '0;
      r_acc       <= '0;
      r_head      <= 1'b0;
      r_q_count   <= 2'd0;
      r_overflow  <= 1'b0;
      r_row_count <= '0;
    end else begin
      if (w_push) begin
        r_nib_idx <= '0;
        r_acc     <= '0;
      end else if (w_accept) begin
        r_nib_idx <= r_nib_idx + 5'd1;
        r_acc     <= w_acc_next;
      end

      case ({w_push, w_pop})
        2'b10:   r_q_count <= r_q_count + 2'd1;
        2'b01:   r_q_count <= r_q_count - 2'd1;
        default: r_q_count <= r_q_count;
      endcase

      if (w_pop) begin
        r_head      <= ~r_head;
        r_row_count <= r_row_count + 1'b1;
      end

      if (w_drop)       r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  // NOTE: queue storage has no reset; r_q_count gates every read, so stale entries never escape.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q_data[w_tail] <= w_acc_next;
      r_q_nib[w_tail]  <= w_push_nib;
    end
  end

  assign out_data    = out_valid ? r_q_data[r_head] : '0;
  assign out_nibbles = out_valid ? r_q_nib[r_head]  : 5'd0;
  assign overflow    = r_overflow;
  assign row_count   = r_row_count;

  a_no_push_when_full: assert property (@(posedge CLK) disable iff (RST)
    !(w_push && (r_q_count == 2'd2)));

endmodule

// File: tb/tb_fifo_row_packer.sv
// Scoreboard bench for fifo_row_packer: a default instance for the directed scenarios
// and a 2-nibble, 3-bit-counter instance for the minimum row size and row_count wrap.
module tb_fifo_row_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  nib;
  } row_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid, flush, clr_ovf, out_ready;
  logic [3:0]  in_data;
  logic        in_ready, out_valid, overflow;
  logic [31:0] out_data;
  logic [4:0]  out_nibbles;
  logic [15:0] row_count;

  logic        wr_in_valid, wr_flush, wr_clr_ovf, wr_out_ready;
  logic [3:0]  wr_in_data;
  logic        wr_in_ready, wr_out_valid, wr_overflow;
  logic [7:0]  wr_out_data;
  logic [4:0]  wr_out_nibbles;
  logic [2:0]  wr_row_count;

  row_t        exp_q[$];
  logic [7:0]  wexp_q[$];
  row_t        m_exp;
  logic [7:0]  wm_exp;
  logic [15:0] m_rows;
  logic [2:0]  wm_rows;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 CLK = ~CLK;

  fifo_row_packer #(.NIBBLES_PER_ROW(8), .CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_nibbles(out_nibbles), .overflow(overflow), .row_count(row_count)
  );

  fifo_row_packer #(.NIBBLES_PER_ROW(2), .CNT_W(3)) u_wrap (
    .CLK(CLK), .RST(RST), .in_valid(wr_in_valid), .in_data(wr_in_data), .in_ready(wr_in_ready),
    .flush(wr_flush), .clr_ovf(wr_clr_ovf), .out_valid(wr_out_valid), .out_ready(wr_out_ready),
    .out_data(wr_out_data), .out_nibbles(wr_out_nibbles), .overflow(wr_overflow),
    .row_count(wr_row_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d,
                       input logic f = 1'b0, input logic c = 1'b0);
    in_valid = v;
    in_data  = d;
    flush    = f;
    clr_ovf  = c;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0);
  endtask

  // Scoreboards: compare the queue head on every handshake, track row_count every cycle.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      m_rows = '0;
    end else begin
      check("row_count", 64'(row_count), 64'(m_rows));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_row", 64'(exp_q.size()), 64'd1);
        end else begin
          m_exp = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(m_exp.data));
          check("out_nibbles", 64'(out_nibbles), 64'(m_exp.nib));
        end
        m_rows = m_rows + 16'd1;
      end
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      wexp_q.delete();
      wm_rows = '0;
    end else begin
      check("wrap_row_count", 64'(wr_row_count), 64'(wm_rows));
      if (wr_out_valid && wr_out_ready) begin
        if (wexp_q.size() == 0) begin
          check("wrap_spurious_row", 64'(wexp_q.size()), 64'd1);
        end else begin
          wm_exp = wexp_q.pop_front();
          check("wrap_out_data", 64'(wr_out_data), 64'(wm_exp));
          check("wrap_out_nibbles", 64'(wr_out_nibbles), 64'd2);
        end
        wm_rows = wm_rows + 3'd1;
      end
    end
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_data = 4'h0; flush = 1'b0; clr_ovf = 1'b0; out_ready = 1'b1;
    wr_in_valid = 1'b0; wr_in_data = 4'h0; wr_flush = 1'b0; wr_clr_ovf = 1'b0; wr_out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // 1: reset values, then nibbles 1..8 back-to-back
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_nibbles", 64'(out_nibbles), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_row_count", 64'(row_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back('{data: 32'h8765_4321, nib: 5'd8});
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'(i));
      if (i == 7) check("t1_no_early_valid", 64'(out_valid), 64'd0);
    end
    check("t1_valid_latency", 64'(out_valid), 64'd1);
    check("t1_head_data", 64'(out_data), 64'h8765_4321);
    idle(2);
    check("t1_row_count", 64'(row_count), 64'd1);

    // 2: stalled output, queue fills, drop sets overflow
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 7 || i == 15) exp_q.push_back('{data: 32'hAAAA_AAAA, nib: 5'd8});
      drive(1'b1, 4'hA);
    end
    check("t2_in_ready_mid", 64'(in_ready), 64'd1);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'hA);
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    drive(1'b1, 4'hA);
    check("t2_overflow_set", 64'(overflow), 64'd1);
    check("t2_head_stable", 64'(out_data), 64'hAAAA_AAAA);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    check("t2_overflow_clr", 64'(overflow), 64'd0);
    drive(1'b1, 4'h5, 1'b0, 1'b1);
    check("t2_set_beats_clr", 64'(overflow), 64'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    check("t2_overflow_clr2", 64'(overflow), 64'd0);
    drive(1'b0, 4'h0, 1'b1);
    check("t2_flush_full_ignored", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    idle(3);
    check("t2_drained", 64'(exp_q.size()), 64'd0);
    exp_q.push_back('{data: 32'h0AAA_AAAA, nib: 5'd7});
    drive(1'b0, 4'h0, 1'b1);
    idle(2);

    // 3: partial row via flush, next row restarts at nibble 0
    exp_q.push_back('{data: 32'h0000_05C3, nib: 5'd3});
    drive(1'b1, 4'h3); drive(1'b1, 4'hC); drive(1'b1, 4'h5);
    drive(1'b0, 4'h0, 1'b1);
    exp_q.push_back('{data: 32'h0000_0001, nib: 5'd1});
    drive(1'b1, 4'h1);
    drive(1'b0, 4'h0, 1'b1);
    idle(2);

    // 4: flush together with an accept, partial and completing
    exp_q.push_back('{data: 32'h0000_9432, nib: 5'd4});
    drive(1'b1, 4'h2); drive(1'b1, 4'h3); drive(1'b1, 4'h4);
    drive(1'b1, 4'h9, 1'b1);
    idle(3);
    check("t4_single_push", 64'(out_valid), 64'd0);
    exp_q.push_back('{data: 32'h7654_3210, nib: 5'd8});
    for (int i = 0; i < 7; i++) drive(1'b1, 4'(i));
    drive(1'b1, 4'h7, 1'b1);
    idle(3);
    check("t4_full_flush_single", 64'(out_valid), 64'd0);
    check("t4_drained", 64'(exp_q.size()), 64'd0);

    // 5: push and pop in the same cycle with one row queued
    out_ready = 1'b0;
    exp_q.push_back('{data: 32'h1111_1111, nib: 5'd8});
    for (int i = 0; i < 8; i++) drive(1'b1, 4'h1);
    exp_q.push_back('{data: 32'h2222_2222, nib: 5'd8});
    for (int i = 0; i < 7; i++) drive(1'b1, 4'h2);
    out_ready = 1'b1;
    drive(1'b1, 4'h2);
    out_ready = 1'b0;
    check("t5_valid_kept", 64'(out_valid), 64'd1);
    check("t5_order", 64'(out_data), 64'h2222_2222);
    idle(1);
    check("t5_count_one", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    idle(2);
    check("t5_empty", 64'(out_valid), 64'd0);

    // 5b: minimum row size and row_count wrap on the small instance
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) wexp_q.push_back({4'(i), 4'(i - 1)});
      wr_in_valid = 1'b1;
      wr_in_data  = 4'(i);
      @(posedge CLK);
      #1;
    end
    wr_in_valid = 1'b0;
    idle(3);
    check("wrap_to_zero", 64'(wr_row_count), 64'd0);
    check("wrap_drained", 64'(wexp_q.size()), 64'd0);

    // 6: reset mid-row with two rows queued
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 7 || i == 15) exp_q.push_back('{data: 32'h3333_3333, nib: 5'd8});
      drive(1'b1, 4'h3);
    end
    for (int i = 0; i < 5; i++) drive(1'b1, 4'h4);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_row_count", 64'(row_count), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    exp_q.push_back('{data: 32'h8765_4321, nib: 5'd8});
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 4'(i));
      if (i == 7) check("t6_idx_restart", 64'(out_valid), 64'd0);
    end
    check("t6_row_after_reset", 64'(out_valid), 64'd1);
    idle(3);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
